filter_autoscale_control_mc: RTL

FILTER_AUTOSCALE_CONTROL_MC -- requirements
Module: filter_autoscale_control_mc

---
 rtl/filter_autoscale_control_mc.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/filter_autoscale_control_mc.sv
// ----------------------------------------------------------------------------
// filter_autoscale_control_mc
// Adjusts the delay of a moving-average filter so that its output amplitude
// stays inside a hold window. Four pipeline stages, all advanced by CE:
//   stage 0: saturating abs of both inputs
//   stage 1: amplitude estimate max + min/2 (registered to AMPLITUDE)
//   stage 2: INC / DEC / HOLD decision against AMP_LOW / AMP_HIGH
//   stage 3: vote counter, clamped DELAY step, DELAY_UPDATED pulse
//
// Optional feature macro: AUTOSCALE_SAT_FAST_EN
//   defined   : a saturated sample halves DELAY at once (floor MIN_DELAY)
//   undefined : saturated samples are ordinary DEC votes
//
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   CE                clock enable; low freezes every register
//   UPDATE            one-cycle strobe qualifying TOP_SIN / TOP_COS
//   TOP_SIN, TOP_COS  signed top bits of the filter outputs
//   FREEZE            blocks DELAY changes at stage 3
//   DELAY             current filter delay
//   DELAY_UPDATED     one CE cycle pulse when DELAY changed
//   AMPLITUDE         last amplitude estimate
// ----------------------------------------------------------------------------
module filter_autoscale_control_mc #(
    parameter int unsigned TOP_DATA_BITS = 4,
    parameter int unsigned DELAY_BITS    = 4,
    parameter int unsigned MIN_DELAY     = 1,
    parameter int unsigned MAX_DELAY     = 15,
    parameter int unsigned INIT_DELAY    = 8,
    parameter int unsigned AMP_LOW       = 2,
    parameter int unsigned AMP_HIGH      = 5,
    parameter int unsigned VOTES         = 2
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic                            CE,
    input  logic                            UPDATE,
    input  logic signed [TOP_DATA_BITS-1:0] TOP_SIN,
    input  logic signed [TOP_DATA_BITS-1:0] TOP_COS,
    input  logic                            FREEZE,
    output logic        [DELAY_BITS-1:0]    DELAY,
    output logic                            DELAY_UPDATED,
    output logic        [TOP_DATA_BITS-2:0] AMPLITUDE
);

    localparam int unsigned AW  = TOP_DATA_BITS - 1;
    localparam int unsigned SW  = AW + 1;
    localparam int unsigned CW  = 4;
    localparam int unsigned DW1 = DELAY_BITS + 1;
    localparam logic [AW-1:0] AMP_MAX = {AW{1'b1}};

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2
    } action_t;

    // Magnitude of a signed sample; the most-negative code maps to AMP_MAX.
    function automatic logic [AW-1:0] sat_abs(input logic signed [TOP_DATA_BITS-1:0] x);
        logic [TOP_DATA_BITS-1:0] neg;
        neg = ~x + TOP_DATA_BITS'(1);
        if (!x[TOP_DATA_BITS-1]) begin
            return x[AW-1:0];
        end
        if (neg[TOP_DATA_BITS-1]) begin
            return AMP_MAX;
        end
        return neg[AW-1:0];
    endfunction

    logic          r_v0;
    logic          r_v1;
    logic          r_v2;
    logic [AW-1:0] r_abs_sin;
    logic [AW-1:0] r_abs_cos;
    action_t       r_act;
    logic [CW-1:0] r_cnt;
    logic          r_dir_dec;

    logic [AW-1:0]         w_abs_sin;
    logic [AW-1:0]         w_abs_cos;
    logic [AW-1:0]         w_max;
    logic [AW-1:0]         w_min;
    logic [SW-1:0]         w_sum;
    logic [AW-1:0]         w_amp;
    action_t               w_act;
    logic                  w_act_dec;
    logic [CW-1:0]         w_cnt_plus;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_dir_nxt;
    logic                  w_step;
    logic [DW1-1:0]        w_tgt;
    logic [DELAY_BITS-1:0] w_delay_nxt;
    logic                  w_upd_nxt;

`ifdef AUTOSCALE_SAT_FAST_EN
    logic r_sat0;
    logic r_sat1;
    logic r_sat2;
    logic w_sat0;
`endif

    // Stage 0: magnitudes.
    always_comb begin
        w_abs_sin = sat_abs(TOP_SIN);
        w_abs_cos = sat_abs(TOP_COS);
`ifdef AUTOSCALE_SAT_FAST_EN
        w_sat0    = (w_abs_sin == AMP_MAX) || (w_abs_cos == AMP_MAX);
`endif
    end

    // Stage 1: alpha-max-beta-min estimate with one spare bit for saturation.
    always_comb begin
        w_max = (r_abs_sin >= r_abs_cos) ? r_abs_sin : r_abs_cos;
        w_min = (r_abs_sin >= r_abs_cos) ? r_abs_cos : r_abs_sin;
        w_sum = SW'(w_max) + SW'(w_min >> 1);
        w_amp = (w_sum > SW'(AMP_MAX)) ? AMP_MAX : w_sum[AW-1:0];
    end

    // Stage 2: window decision on the registered amplitude.
    always_comb begin
        w_act = ACT_HOLD;
        if (32'(AMPLITUDE) > AMP_HIGH) begin
            w_act = ACT_DEC;
        end else if (32'(AMPLITUDE) < AMP_LOW) begin
            w_act = ACT_INC;
        end
    end

    // Stage 3: voting and clamped delay step.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir_dec;
        w_delay_nxt = DELAY;
        w_upd_nxt   = 1'b0;
        w_step      = 1'b0;
        w_tgt       = DW1'(DELAY);
        w_act_dec   = (r_act == ACT_DEC);
        w_cnt_plus  = (w_act_dec == r_dir_dec) ? (r_cnt + CW'(1)) : CW'(1);
        if (r_v2) begin
            if (FREEZE) begin
                w_cnt_nxt = '0;
            end
`ifdef AUTOSCALE_SAT_FAST_EN
            else if (r_sat2) begin
                w_cnt_nxt = '0;
                w_step    = 1'b1;
                w_tgt     = DW1'(DELAY >> 1);
                if (w_tgt < DW1'(MIN_DELAY)) begin
                    w_tgt = DW1'(MIN_DELAY);
                end
            end
`endif
            else if (r_act == ACT_HOLD) begin
                w_cnt_nxt = '0;
            end else begin
                w_dir_nxt = w_act_dec;
                if (w_cnt_plus == CW'(VOTES)) begin
                    w_cnt_nxt = '0;
                    w_step    = 1'b1;
                    if (w_act_dec) begin
                        w_tgt = (DW1'(DELAY) > DW1'(MIN_DELAY)) ? (DW1'(DELAY) - DW1'(1))
                                                                 : DW1'(MIN_DELAY);
                    end else begin
                        w_tgt = DW1'(DELAY) + DW1'(1);
                        if (w_tgt > DW1'(MAX_DELAY)) begin
                            w_tgt = DW1'(MAX_DELAY);
                        end
                    end
                end else begin
                    w_cnt_nxt = w_cnt_plus;
                end
            end
            // A step clamped onto the current value is silent.
            if (w_step && (w_tgt[DELAY_BITS-1:0] != DELAY)) begin
                w_delay_nxt = w_tgt[DELAY_BITS-1:0];
                w_upd_nxt   = 1'b1;
            end
        end
    end

    // Pipeline and control state; CE low holds everything, pulse included.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v0          <= 1'b0;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_abs_sin     <= '0;
            r_abs_cos     <= '0;
            r_act         <= ACT_HOLD;
            r_cnt         <= '0;
            r_dir_dec     <= 1'b0;
            AMPLITUDE     <= '0;
            DELAY         <= DELAY_BITS'(INIT_DELAY);
            DELAY_UPDATED <= 1'b0;
`ifdef AUTOSCALE_SAT_FAST_EN
            r_sat0        <= 1'b0;
            r_sat1        <= 1'b0;
            r_sat2        <= 1'b0;
`endif
        end else if (CE) begin
            r_v0          <= UPDATE;
            r_abs_sin     <= w_abs_sin;
            r_abs_cos     <= w_abs_cos;
            r_v1          <= r_v0;
            if (r_v0) begin
                AMPLITUDE <= w_amp;
            end
            r_v2          <= r_v1;
            r_act         <= w_act;
            r_cnt         <= w_cnt_nxt;
            r_dir_dec     <= w_dir_nxt;
            DELAY         <= w_delay_nxt;
            DELAY_UPDATED <= w_upd_nxt;
`ifdef AUTOSCALE_SAT_FAST_EN
            r_sat0        <= w_sat0;
            r_sat1        <= r_sat0;
            r_sat2        <= r_sat1;
`endif
        end
    end

endmodule
